// File: rtl/cabin_pkg.sv
// Shared codes for the cabin zone controller: state encodings, phase
// codes, per-zone light modes and the Moore rule decode.
package cabin_pkg;

    localparam int STATE_W = 4;

    // State encodings (state_debug reports these directly)
    localparam logic [3:0] ST_GROUND  = 4'd0;
    localparam logic [3:0] ST_TAXI    = 4'd1;
    localparam logic [3:0] ST_TAKEOFF = 4'd2;
    localparam logic [3:0] ST_CLIMB   = 4'd3;
    localparam logic [3:0] ST_CRUISE  = 4'd4;
    localparam logic [3:0] ST_DESCENT = 4'd5;
    localparam logic [3:0] ST_LANDING = 4'd6;
    localparam logic [3:0] ST_FAULT   = 4'd7;
    localparam logic [3:0] ST_MAINT   = 4'd8;

    // Raw flight phase codes
    localparam logic [2:0] PH_GROUND  = 3'd0;
    localparam logic [2:0] PH_TAXI    = 3'd1;
    localparam logic [2:0] PH_TAKEOFF = 3'd2;
    localparam logic [2:0] PH_CLIMB   = 3'd3;
    localparam logic [2:0] PH_CRUISE  = 3'd4;
    localparam logic [2:0] PH_DESCENT = 3'd5;
    localparam logic [2:0] PH_LANDING = 3'd6;
    localparam logic [2:0] PH_INVALID = 3'd7;

    // Per-zone light modes
    localparam logic [1:0] LM_DIM       = 2'b01;
    localparam logic [1:0] LM_BRIGHT    = 2'b10;
    localparam logic [1:0] LM_EMERGENCY = 2'b11;

    typedef struct packed {
        logic       locked;
        logic       seatbelt;
        logic       force_en;
        logic       fault;
        logic [1:0] mode;
    } cabin_rules_t;

    // Map a valid phase onto its flight state; invalid phase maps to FAULT.
    function automatic logic [3:0] phase_to_state(input logic [2:0] ph);
        logic [3:0] st;
        case (ph)
            PH_GROUND:  st = ST_GROUND;
            PH_TAXI:    st = ST_TAXI;
            PH_TAKEOFF: st = ST_TAKEOFF;
            PH_CLIMB:   st = ST_CLIMB;
            PH_CRUISE:  st = ST_CRUISE;
            PH_DESCENT: st = ST_DESCENT;
            PH_LANDING: st = ST_LANDING;
            default:    st = ST_FAULT;
        endcase
        return st;
    endfunction

    // Cabin rules for a state; any unknown code is treated as FAULT.
    function automatic cabin_rules_t decode_rules(input logic [3:0] st);
        cabin_rules_t r;
        case (st)
            ST_GROUND, ST_CRUISE:
                r = '{locked: 1'b0, seatbelt: 1'b0, force_en: 1'b0, fault: 1'b0, mode: LM_DIM};
            ST_TAXI, ST_DESCENT:
                r = '{locked: 1'b0, seatbelt: 1'b1, force_en: 1'b1, fault: 1'b0, mode: LM_DIM};
            ST_TAKEOFF, ST_CLIMB, ST_LANDING:
                r = '{locked: 1'b1, seatbelt: 1'b1, force_en: 1'b1, fault: 1'b0, mode: LM_DIM};
            ST_MAINT:
                r = '{locked: 1'b1, seatbelt: 1'b1, force_en: 1'b1, fault: 1'b0, mode: LM_BRIGHT};
            default:
                r = '{locked: 1'b1, seatbelt: 1'b1, force_en: 1'b1, fault: 1'b1, mode: LM_EMERGENCY};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cabin_phase_debounce.sv
// Flight phase debouncer: a phase is accepted once it has been sampled
// STABLE_CYCLES times in a row.
module cabin_phase_debounce
    import cabin_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] phase_i,
    output logic [2:0] stable_phase_o
);

    localparam logic [7:0] TARGET = 8'(STABLE_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic [2:0] prev_q;
    logic [2:0] stable_q, stable_d;

    // Run-length counter and acceptance of the sampled phase
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (phase_i != prev_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q < TARGET) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_d == TARGET) begin
            stable_d = phase_i;
        end else begin
            stable_d = stable_q;
        end
    end

    // Debounce state registers; frozen while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 8'd0;
            prev_q   <= PH_GROUND;
            stable_q <= PH_GROUND;
        end else if (en) begin
            cnt_q    <= cnt_d;
            prev_q   <= phase_i;
            stable_q <= stable_d;
        end
    end

    assign stable_phase_o = stable_q;

endmodule

// File: rtl/cabin_zone_ctrl.sv
// Cabin zone controller: flight-phase driven state machine with fault
// latching, maintenance mode, takeoff/landing dwell lock and per-zone
// alert lighting.
module cabin_zone_ctrl
    import cabin_pkg::*;
#(
    parameter int N_ZONES       = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int LOCK_HOLD     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [2:0]             flight_phase,
    input  logic                   maint_req,
    input  logic [N_ZONES-1:0]     zone_fault,
    input  logic                   fault_clear,
    output logic                   system_locked,
    output logic                   seatbelt_force_on,
    output logic                   lighting_force_en,
    output logic [2*N_ZONES-1:0]   zone_light_mode,
    output logic [N_ZONES-1:0]     zone_alert,
    output logic                   fault_alert,
    output logic                   maint_reject,
    output logic [3:0]             state_debug
);

    localparam logic [7:0] DWELL_LOAD = 8'(LOCK_HOLD);

    logic [3:0]         state_q, state_d;
    logic [7:0]         dwell_q, dwell_d;
    logic [N_ZONES-1:0] alert_q, alert_d;
    logic               maint_prev_q;
    logic               reject_q, reject_d;
    logic [2:0]         stable_phase_s;
    logic               in_fault_s;
    logic               in_lock_s;
    cabin_rules_t       rules_s;

    cabin_phase_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .phase_i        (flight_phase),
        .stable_phase_o (stable_phase_s)
    );

    // Undefined state codes are handled exactly like FAULT
    assign in_fault_s = (state_q == ST_FAULT) || (state_q > ST_MAINT);
    assign in_lock_s  = (state_q == ST_TAKEOFF) || (state_q == ST_LANDING);

    // Next-state selection: maintenance, then fault, then dwell, then phase
    always_comb begin
        state_d = state_q;
        if (state_q == ST_MAINT) begin
            if (maint_req) begin
                state_d = ST_MAINT;
            end else if (stable_phase_s == PH_GROUND) begin
                state_d = ST_GROUND;
            end else begin
                state_d = ST_FAULT;
            end
        end else if (maint_req && (state_q == ST_GROUND)) begin
            state_d = ST_MAINT;
        end else if ((|zone_fault) || (stable_phase_s == PH_INVALID)) begin
            state_d = ST_FAULT;
        end else if (in_fault_s) begin
            if (fault_clear) begin
                state_d = phase_to_state(stable_phase_s);
            end else begin
                state_d = ST_FAULT;
            end
        end else if (in_lock_s && (dwell_q != 8'd0)) begin
            state_d = state_q;
        end else begin
            state_d = phase_to_state(stable_phase_s);
        end
    end

    // Dwell counter: reload on entry to a locked phase, otherwise count down
    always_comb begin
        dwell_d = dwell_q;
        if (((state_d == ST_TAKEOFF) || (state_d == ST_LANDING)) && (state_d != state_q)) begin
            dwell_d = DWELL_LOAD;
        end else if (dwell_q != 8'd0) begin
            dwell_d = dwell_q - 8'd1;
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Zone alerts: a set always wins over a clear in the same cycle
    always_comb begin
        alert_d  = (alert_q & ~({N_ZONES{fault_clear}} & ~zone_fault)) | zone_fault;
        reject_d = maint_req && !maint_prev_q &&
                   (state_q != ST_GROUND) && (state_q != ST_MAINT);
    end

    // Control registers; en low freezes everything except the reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_GROUND;
            dwell_q      <= 8'd0;
            alert_q      <= '0;
            maint_prev_q <= 1'b0;
            reject_q     <= 1'b0;
        end else if (en) begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            alert_q      <= alert_d;
            maint_prev_q <= maint_req;
            reject_q     <= reject_d;
        end else begin
            reject_q     <= 1'b0;
        end
    end

    // Moore output decode from the state and alert registers
    always_comb begin
        rules_s           = decode_rules(state_q);
        system_locked     = rules_s.locked;
        seatbelt_force_on = rules_s.seatbelt;
        lighting_force_en = rules_s.force_en;
        fault_alert       = rules_s.fault;
        zone_light_mode   = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (alert_q[i]) begin
                zone_light_mode[2*i +: 2] = LM_EMERGENCY;
            end else begin
                zone_light_mode[2*i +: 2] = rules_s.mode;
            end
        end
    end

    assign zone_alert   = alert_q;
    assign maint_reject = reject_q;
    assign state_debug  = state_q;

endmodule
